rf_wport_arbiter: RTL and testbench

- Shares the register file's single write port between the pipeline writeback stage (WB) and a long-latency unit (LLU: multiply/divide) that returns results out of pipeline order.
- Keeps a per-register busy scoreboard for LLU destinations and raises a decode hazard on RAW/WAW conflicts.
- Forces a one-cycle WB hold when the LLU has waited too long.
- Sits between the MEM/WB register, the LLU and the register-file write inputs.

---
 rtl/rf_wport_arbiter_pkg.sv | 7 +
 rtl/rf_wport_arbiter_scoreboard.sv | 27 ++
 rtl/rf_wport_arbiter.sv | 63 ++++++
 tb/tb_rf_wport_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: shared constants and arbiter state encoding
package rf_wport_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_FORCE = 1'b1} arb_state_e;
endpackage

// File: rtl/rf_wport_arbiter_scoreboard.sv
// rf_scoreboard: busy bits for in-flight LLU destinations with issue and hazard lookups
module rf_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREG = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              issue_ready_o,
  input  logic              commit_i,
  input  logic [ADDR_W-1:0] commit_rd_i,
  input  logic [ADDR_W-1:0] dec_rs_i,
  input  logic [ADDR_W-1:0] dec_rt_i,
  input  logic [ADDR_W-1:0] dec_rd_i,
  input  logic              dec_rd_valid_i,
  output logic              hazard_o
);
  logic [NREG-1:0] busy, set_mask, clr_mask;
  assign issue_ready_o = rst_i & ~busy[issue_rd_i];
  assign set_mask = (issue_i & issue_ready_o) ? NREG'(1) << issue_rd_i : '0;
  assign clr_mask = commit_i ? NREG'(1) << commit_rd_i : '0;
  assign hazard_o = rst_i & (busy[dec_rs_i] | busy[dec_rt_i] | (dec_rd_valid_i & busy[dec_rd_i]));
  // set after clear so a same-cycle issue wins; r0 is never tracked
  always_ff @(posedge clk_i)
    busy <= !rst_i ? '0 : ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the register-file write port between WB and the long-latency unit
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NREG = 2 ** ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_hold_o,
  input  logic              llu_valid_i,
  input  logic [ADDR_W-1:0] llu_rd_i,
  input  logic [DATA_W-1:0] llu_data_i,
  output logic              llu_ready_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              issue_ready_o,
  input  logic [ADDR_W-1:0] dec_rs_i,
  input  logic [ADDR_W-1:0] dec_rt_i,
  input  logic [ADDR_W-1:0] dec_rd_i,
  input  logic              dec_rd_valid_i,
  output logic              hazard_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0] rf_data_o
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  arb_state_e state, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_n;
  logic wb_busy, forcing, use_llu, starve, to_force;
  assign wb_busy = wb_we_i & (wb_rd_i != ADDR_W'(REG_ZERO));
  assign forcing = state == ARB_FORCE;
  assign wb_hold_o = rst_i & forcing;
  assign llu_ready_o = rst_i & llu_valid_i & (forcing | ~wb_busy);
  assign use_llu = llu_valid_i & (forcing | ~wb_busy);
  assign starve = rst_i & ~forcing & llu_valid_i & wb_busy;
  assign to_force = starve & (int'(wait_cnt) + 1 >= STARVE_LIMIT - 1);
  assign rf_we_o = rst_i & (use_llu ? llu_rd_i != ADDR_W'(REG_ZERO) : ~forcing & wb_busy);
  assign rf_rd_o = !rst_i ? '0 : use_llu ? llu_rd_i : wb_rd_i;
  assign rf_data_o = !rst_i ? '0 : use_llu ? llu_data_i : wb_data_i;
  // FORCE lasts exactly one cycle: the LLU either commits or has dropped valid
  always_comb begin
    state_n = forcing ? ARB_IDLE : to_force ? ARB_FORCE : ARB_IDLE;
    wait_n = (starve & ~to_force) ? wait_cnt + CNT_W'(1) : '0;
  end
  // arbiter state and starvation counter
  always_ff @(posedge clk_i) begin
    state <= !rst_i ? ARB_IDLE : state_n;
    wait_cnt <= !rst_i ? '0 : wait_n;
  end
  rf_scoreboard #(.ADDR_W(ADDR_W), .NREG(NREG)) u_sb (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .commit_i(llu_ready_o), .commit_rd_i(llu_rd_i),
    .dec_rs_i(dec_rs_i), .dec_rt_i(dec_rt_i), .dec_rd_i(dec_rd_i),
    .dec_rd_valid_i(dec_rd_valid_i), .hazard_o(hazard_o)
  );
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed vectors with hand-computed expectations
module tb_rf_wport_arbiter;
  logic clk_i = 0, rst_i;
  logic wb_we_i, llu_valid_i, issue_i, dec_rd_valid_i;
  logic [4:0] wb_rd_i, llu_rd_i, issue_rd_i, dec_rs_i, dec_rt_i, dec_rd_i;
  logic [31:0] wb_data_i, llu_data_i;
  logic wb_hold_o, llu_ready_o, issue_ready_o, hazard_o, rf_we_o;
  logic [4:0] rf_rd_o;
  logic [31:0] rf_data_o;
  int checks = 0, errors = 0;

  rf_wport_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_hold_o(wb_hold_o),
    .llu_valid_i(llu_valid_i), .llu_rd_i(llu_rd_i), .llu_data_i(llu_data_i), .llu_ready_o(llu_ready_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .dec_rs_i(dec_rs_i), .dec_rt_i(dec_rt_i), .dec_rd_i(dec_rd_i), .dec_rd_valid_i(dec_rd_valid_i),
    .hazard_o(hazard_o), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
    llu_valid_i = 0; llu_rd_i = 0; llu_data_i = 0;
    issue_i = 0; issue_rd_i = 0;
    dec_rs_i = 0; dec_rt_i = 0; dec_rd_i = 0; dec_rd_valid_i = 0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_we_i = 1; wb_rd_i = rd; wb_data_i = d;
  endtask

  task automatic llu(input logic [4:0] rd, input logic [31:0] d);
    llu_valid_i = 1; llu_rd_i = rd; llu_data_i = d;
  endtask

  initial begin
    quiet();
    rst_i = 0;
    wb(5, 32'h1234); llu(6, 32'h66); issue_i = 1; issue_rd_i = 2;
    tick(); tick();
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_rf_rd", rf_rd_o, 0);
    chk("rst_rf_data", rf_data_o, 0);
    chk("rst_llu_ready", llu_ready_o, 0);
    chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_hold", wb_hold_o, 0);
    rst_i = 1; quiet(); dec_rs_i = 2; #1;
    chk("idle_hazard", hazard_o, 0);
    chk("idle_rf_we", rf_we_o, 0);
    chk("idle_issue_ready", issue_ready_o, 1);
    tick();
    // WB only
    wb(5, 32'h1234); #1;
    chk("wb_we", rf_we_o, 1);
    chk("wb_rd", rf_rd_o, 5);
    chk("wb_data", rf_data_o, 32'h1234);
    chk("wb_llu_ready", llu_ready_o, 0);
    tick(); quiet();
    // LLU uncontended
    issue_i = 1; issue_rd_i = 8; #1;
    chk("issue8_ready", issue_ready_o, 1);
    tick(); quiet(); dec_rs_i = 8; #1;
    chk("haz_rs8", hazard_o, 1);
    dec_rs_i = 0; dec_rt_i = 8; #1;
    chk("haz_rt8", hazard_o, 1);
    llu(8, 32'hCAFE); #1;
    chk("llu8_ready", llu_ready_o, 1);
    chk("llu8_we", rf_we_o, 1);
    chk("llu8_rd", rf_rd_o, 8);
    chk("llu8_data", rf_data_o, 32'hCAFE);
    chk("llu8_haz_commit_cycle", hazard_o, 1);
    tick(); quiet(); dec_rs_i = 8; #1;
    chk("haz8_cleared", hazard_o, 0);
    // destination check depends on dec_rd_valid_i
    issue_i = 1; issue_rd_i = 10;
    tick(); quiet(); dec_rd_i = 10; #1;
    chk("haz_rd10_novalid", hazard_o, 0);
    dec_rd_valid_i = 1; #1;
    chk("haz_rd10_valid", hazard_o, 1);
    quiet();
    // starvation
    issue_i = 1; issue_rd_i = 9;
    tick(); quiet();
    wb(3, 32'h33); llu(9, 32'h99);
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("starve_c%0d_ready", c), llu_ready_o, 0);
      chk($sformatf("starve_c%0d_hold", c), wb_hold_o, 0);
      chk($sformatf("starve_c%0d_rd", c), rf_rd_o, 3);
      tick();
    end
    chk("force_hold", wb_hold_o, 1);
    chk("force_ready", llu_ready_o, 1);
    chk("force_we", rf_we_o, 1);
    chk("force_rd", rf_rd_o, 9);
    chk("force_data", rf_data_o, 32'h99);
    tick();
    llu_valid_i = 0; dec_rs_i = 9; #1;
    chk("resume_hold", wb_hold_o, 0);
    chk("resume_we", rf_we_o, 1);
    chk("resume_rd", rf_rd_o, 3);
    chk("resume_haz9", hazard_o, 0);
    tick(); quiet();
    // double issue to the same register
    issue_i = 1; issue_rd_i = 7; #1;
    chk("issue7_first", issue_ready_o, 1);
    tick(); #1;
    chk("issue7_second", issue_ready_o, 0);
    tick(); quiet(); llu(7, 32'h77); #1;
    chk("commit7_ready", llu_ready_o, 1);
    tick(); quiet(); dec_rs_i = 7; #1;
    chk("haz7_cleared", hazard_o, 0);
    issue_i = 1; issue_rd_i = 7; llu(7, 32'h7); #1;
    chk("issue7_with_commit", issue_ready_o, 1);
    tick(); quiet(); dec_rs_i = 7; #1;
    chk("haz7_set_wins", hazard_o, 1);
    quiet();
    // issue to r0
    issue_i = 1; issue_rd_i = 0; #1;
    chk("issue0_ready", issue_ready_o, 1);
    tick(); quiet(); #1;
    chk("haz_r0", hazard_o, 0);
    // WB to r0 does not block LLU
    wb(0, 32'h5); llu(12, 32'hAB); #1;
    chk("wb0_llu_ready", llu_ready_o, 1);
    chk("wb0_llu_we", rf_we_o, 1);
    chk("wb0_llu_rd", rf_rd_o, 12);
    tick(); quiet();
    // LLU to r0 commits without a write
    llu(0, 32'hEE); #1;
    chk("llu0_ready", llu_ready_o, 1);
    chk("llu0_we", rf_we_o, 0);
    tick(); quiet();
    // reset while forcing
    issue_i = 1; issue_rd_i = 4;
    tick(); quiet();
    wb(3, 32'h33); llu(4, 32'h44);
    tick(); tick(); tick();
    chk("rstforce_hold", wb_hold_o, 1);
    rst_i = 0; #1;
    chk("rstforce_hold_gated", wb_hold_o, 0);
    chk("rstforce_we_gated", rf_we_o, 0);
    tick();
    rst_i = 1; dec_rs_i = 4; issue_rd_i = 4; #1;
    chk("after_rst_hold", wb_hold_o, 0);
    chk("after_rst_ready", llu_ready_o, 0);
    chk("after_rst_rd", rf_rd_o, 3);
    chk("after_rst_haz4", hazard_o, 0);
    chk("after_rst_issue4", issue_ready_o, 1);
    tick(); quiet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
